// File: rtl/fa_bist.sv
// Built-in self-test engine for a full adder: sweeps all eight {a,b,cin} vectors,
// checks s/cout against a golden model, and reports pass, error count and first failure.
module fa_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_cin,
  input  logic       dut_s,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);
  // state | meaning
  // IDLE  | waiting for start; results of the last run held
  // RUN   | driving vectors and comparing responses
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] settle;
  logic [2:0] vec;
  logic [3:0] loop_cnt;
  logic       compare, final_cmp, mismatch;
  logic       exp_s, exp_cout;
  logic [3:0] err_nxt;

  assign {dut_a, dut_b, dut_cin} = vec;

  assign compare   = (state == RUN) && (settle == 4'(SETTLE_CYCLES - 1));
  assign final_cmp = compare && (vec == 3'd7) && (loop_cnt == 4'(LOOPS - 1));
  assign exp_s     = ^vec;
  assign exp_cout  = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  assign mismatch  = compare && ((dut_s != exp_s) || (dut_cout != exp_cout));
  // Saturating count including the compare happening this cycle; feeds pass at the final edge.
  assign err_nxt   = (mismatch && (err_count != 4'hf)) ? err_count + 4'd1 : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (final_cmp) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle           <= '0;
      vec              <= '0;
      loop_cnt         <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            settle           <= '0;
            vec              <= '0;
            loop_cnt         <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
          end
        end
        RUN: begin
          if (compare) begin
            settle    <= '0;
            vec       <= vec + 3'd1;
            err_count <= err_nxt;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
            if (final_cmp) begin
              loop_cnt <= '0;
              pass     <= (err_nxt == 4'd0);
            end else if (vec == 3'd7) begin
              loop_cnt <= loop_cnt + 4'd1;
            end
          end else begin
            settle <= settle + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
